// File: rtl/regfile_2r1w_oe_pkg.sv
// Shared helpers for the 2-read/1-write register file: entry gating and
// write-to-read forwarding qualifiers.
package regfile_2r1w_oe_pkg;

  function automatic logic entry_live(input logic zero_r0, input logic addr_is_zero);
    return !(zero_r0 && addr_is_zero);
  endfunction

  function automatic logic fwd_active(input logic bypass, input logic wr_ok, input logic addr_match);
    return bypass && wr_ok && addr_match;
  endfunction

endpackage

// File: rtl/regfile_2r1w_oe_rd_port.sv
// One read port: source select with optional forwarding, 1-cycle capture
// latch, tri-state bus driver and busy-hit flag.
module regfile_2r1w_oe_rd_port
  import regfile_2r1w_oe_pkg::*;
#(
  parameter int N       = 16,
  parameter int A       = 3,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Rd,
  input  logic [A-1:0]               RAddr,
  input  logic                       Oe,
  input  logic                       WrOk,
  input  logic [A-1:0]               WAddr,
  input  logic [N-1:0]               WData,
  input  logic [(2**A)-1:0][N-1:0]   Entries,
  input  logic [(2**A)-1:0]          Busy,
  output wire logic [N-1:0]          Qz,
  output logic                       Hit
);

  logic         fwd_s;
  logic [N-1:0] src_s;
  logic [N-1:0] rl_r;

  // Capture source: forwarded write data, hardwired zero, or stored entry
  always_comb begin
    fwd_s = fwd_active(BYPASS, WrOk, WAddr == RAddr);
    src_s = Entries[RAddr];
    if (fwd_s) begin
      src_s = WData;
    end else if (!entry_live(ZERO_R0, RAddr == {A{1'b0}})) begin
      src_s = {N{1'b0}};
    end else begin
      src_s = Entries[RAddr];
    end
  end

  // Read latch: cleared by reset, loaded on Rd, otherwise held
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rl_r <= {N{1'b0}};
    end else if (Rd) begin
      rl_r <= src_s;
    end
  end

  // A write landing this cycle resolves the hazard, so it does not count as a hit
  assign Hit = Busy[RAddr] & ~fwd_s;
  assign Qz  = Oe ? rl_r : {N{1'bz}};

endmodule

// File: rtl/regfile_2r1w_oe.sv
// Register file, 2^A x N, one write port, two tri-state read ports and a
// per-entry pending-write scoreboard.
module regfile_2r1w_oe
  import regfile_2r1w_oe_pkg::*;
#(
  parameter int N       = 16,
  parameter int A       = 3,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Wr,
  input  logic [A-1:0]         WAddr,
  input  logic [N-1:0]         WData,
  input  logic                 Rd0,
  input  logic [A-1:0]         RAddr0,
  input  logic                 Rd1,
  input  logic [A-1:0]         RAddr1,
  input  logic                 Oe0,
  input  logic                 Oe1,
  input  logic                 Rsv,
  input  logic [A-1:0]         RsvAddr,
  output wire logic [N-1:0]    Qz0,
  output wire logic [N-1:0]    Qz1,
  output logic                 Hit0,
  output logic                 Hit1,
  output logic [(2**A)-1:0]    BusyMask
);

  localparam int DEPTH = 2**A;
  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0][N-1:0] mem_r;
  logic [DEPTH-1:0]        busy_r;
  logic [DEPTH-1:0]        clr_mask_s;
  logic [DEPTH-1:0]        set_mask_s;
  logic [DEPTH-1:0]        busy_nxt_s;
  logic                    wr_ok_s;
  logic                    rsv_ok_s;

  assign wr_ok_s    = Wr  & entry_live(ZERO_R0, WAddr   == {A{1'b0}});
  assign rsv_ok_s   = Rsv & entry_live(ZERO_R0, RsvAddr == {A{1'b0}});
  assign clr_mask_s = wr_ok_s  ? (ONE_HOT0 << WAddr)   : {DEPTH{1'b0}};
  assign set_mask_s = rsv_ok_s ? (ONE_HOT0 << RsvAddr) : {DEPTH{1'b0}};
  // Set applied after clear so a same-entry reserve and write leaves it busy
  assign busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;

  // Entry array and scoreboard state
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_r  <= {(DEPTH*N){1'b0}};
      busy_r <= {DEPTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[WAddr] <= WData;
      end
      busy_r <= busy_nxt_s;
    end
  end

  assign BusyMask = busy_r;

  regfile_2r1w_oe_rd_port #(.N(N), .A(A), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_rd0 (
    .Clk(Clk), .Rst(Rst), .Rd(Rd0), .RAddr(RAddr0), .Oe(Oe0),
    .WrOk(wr_ok_s), .WAddr(WAddr), .WData(WData),
    .Entries(mem_r), .Busy(busy_r), .Qz(Qz0), .Hit(Hit0)
  );

  regfile_2r1w_oe_rd_port #(.N(N), .A(A), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_rd1 (
    .Clk(Clk), .Rst(Rst), .Rd(Rd1), .RAddr(RAddr1), .Oe(Oe1),
    .WrOk(wr_ok_s), .WAddr(WAddr), .WData(WData),
    .Entries(mem_r), .Busy(busy_r), .Qz(Qz1), .Hit(Hit1)
  );

endmodule

// File: tb/tb_regfile_2r1w_oe.sv
// Bench for regfile_2r1w_oe: two instances (default, and ZERO_R0=1/BYPASS=0)
// on pulled-up buses, directed table, corner sequences and random traffic.
`timescale 1ns/1ps
module tb_regfile_2r1w_oe;
  localparam int N = 16;
  localparam int A = 3;
  localparam int D = 8;
  localparam logic [N-1:0] RELEASED = 16'hFFFF;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst, Wr, Rd0, Rd1, Oe0, Oe1, Rsv;
  logic [A-1:0] WAddr, RAddr0, RAddr1, RsvAddr;
  logic [N-1:0] WData;
  tri1 [N-1:0] qa0, qa1, qb0, qb1;
  logic ha0, ha1, hb0, hb1;
  logic [D-1:0] ma, mb;

  regfile_2r1w_oe dut_a (
    .Clk(Clk), .Rst(Rst), .Wr(Wr), .WAddr(WAddr), .WData(WData),
    .Rd0(Rd0), .RAddr0(RAddr0), .Rd1(Rd1), .RAddr1(RAddr1),
    .Oe0(Oe0), .Oe1(Oe1), .Rsv(Rsv), .RsvAddr(RsvAddr),
    .Qz0(qa0), .Qz1(qa1), .Hit0(ha0), .Hit1(ha1), .BusyMask(ma));

  regfile_2r1w_oe #(.N(16), .A(3), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_b (
    .Clk(Clk), .Rst(Rst), .Wr(Wr), .WAddr(WAddr), .WData(WData),
    .Rd0(Rd0), .RAddr0(RAddr0), .Rd1(Rd1), .RAddr1(RAddr1),
    .Oe0(Oe0), .Oe1(Oe1), .Rsv(Rsv), .RsvAddr(RsvAddr),
    .Qz0(qb0), .Qz1(qb1), .Hit0(hb0), .Hit1(hb1), .BusyMask(mb));

  int checks = 0;
  int errors = 0;

  // Reference model: k=0 is dut_a (bypass, no zero entry), k=1 is dut_b
  bit [N-1:0] mem_m [2][D];
  bit         busy_m [2][D];
  bit [N-1:0] rl_m [2][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] read_src(input int k, input logic [A-1:0] ra);
    if (k == 0 && Wr && WAddr == ra) return WData;
    if (k == 1 && ra == 3'd0) return 16'h0000;
    return mem_m[k][ra];
  endfunction

  function automatic logic exp_hit(input int k, input logic [A-1:0] ra);
    return busy_m[k][ra] && !(k == 0 && Wr && WAddr == ra);
  endfunction

  function automatic logic [D-1:0] exp_mask(input int k);
    logic [D-1:0] m;
    for (int i = 0; i < D; i++) m[i] = busy_m[k][i];
    return m;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (Rst) begin
        for (int d = 0; d < D; d++) begin
          mem_m[k][d]  = '0;
          busy_m[k][d] = 1'b0;
        end
        rl_m[k][0] = '0;
        rl_m[k][1] = '0;
      end else begin
        if (Rd0) rl_m[k][0] = read_src(k, RAddr0);
        if (Rd1) rl_m[k][1] = read_src(k, RAddr1);
        if (Wr && !(k == 1 && WAddr == 3'd0)) mem_m[k][WAddr] = WData;
        if (Wr) busy_m[k][WAddr] = 1'b0;
        if (Rsv && !(k == 1 && RsvAddr == 3'd0)) busy_m[k][RsvAddr] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("a_qz0",  qa0, Oe0 ? rl_m[0][0] : RELEASED);
    chk("a_qz1",  qa1, Oe1 ? rl_m[0][1] : RELEASED);
    chk("a_hit0", ha0, exp_hit(0, RAddr0));
    chk("a_hit1", ha1, exp_hit(0, RAddr1));
    chk("a_busy", ma,  exp_mask(0));
    chk("b_qz0",  qb0, Oe0 ? rl_m[1][0] : RELEASED);
    chk("b_qz1",  qb1, Oe1 ? rl_m[1][1] : RELEASED);
    chk("b_hit0", hb0, exp_hit(1, RAddr0));
    chk("b_hit1", hb1, exp_hit(1, RAddr1));
    chk("b_busy", mb,  exp_mask(1));
  endtask

  task automatic set_idle();
    Rst = 1'b0; Wr = 1'b0; WAddr = '0; WData = '0;
    Rd0 = 1'b0; RAddr0 = '0; Rd1 = 1'b0; RAddr1 = '0;
    Oe0 = 1'b0; Oe1 = 1'b0; Rsv = 1'b0; RsvAddr = '0;
  endtask

  task automatic advance();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic wr; logic [A-1:0] waddr; logic [N-1:0] wdata;
    logic rd0; logic [A-1:0] ra0; logic rd1; logic [A-1:0] ra1;
    logic oe0; logic oe1; logic rsv; logic [A-1:0] rsva;
    logic [N-1:0] q0; logic [N-1:0] q1; logic [D-1:0] busy; logic hit0; logic [N-1:0] zq1;
  } vec_t;

  function automatic vec_t V(logic wr, logic [A-1:0] waddr, logic [N-1:0] wdata,
                             logic rd0, logic [A-1:0] ra0, logic rd1, logic [A-1:0] ra1,
                             logic oe0, logic oe1, logic rsv, logic [A-1:0] rsva,
                             logic [N-1:0] q0, logic [N-1:0] q1, logic [D-1:0] busy,
                             logic hit0, logic [N-1:0] zq1);
    vec_t v;
    v.wr = wr; v.waddr = waddr; v.wdata = wdata; v.rd0 = rd0; v.ra0 = ra0;
    v.rd1 = rd1; v.ra1 = ra1; v.oe0 = oe0; v.oe1 = oe1; v.rsv = rsv; v.rsva = rsva;
    v.q0 = q0; v.q1 = q1; v.busy = busy; v.hit0 = hit0; v.zq1 = zq1;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    // Expected outputs are those seen while the row is applied (before its edge)
    tbl[0]  = V(1,3,16'hBEEF, 0,0,0,0, 1,0, 0,0, 16'h0000,16'hFFFF,8'h00,0,16'hFFFF);
    tbl[1]  = V(0,0,16'h0000, 1,3,0,0, 1,0, 0,0, 16'h0000,16'hFFFF,8'h00,0,16'hFFFF);
    tbl[2]  = V(0,0,16'h0000, 0,3,0,0, 1,0, 0,0, 16'hBEEF,16'hFFFF,8'h00,0,16'hFFFF);
    tbl[3]  = V(0,0,16'h0000, 0,3,0,0, 0,0, 0,0, 16'hFFFF,16'hFFFF,8'h00,0,16'hFFFF);
    tbl[4]  = V(1,5,16'h1234, 0,0,1,5, 0,1, 0,0, 16'hFFFF,16'h0000,8'h00,0,16'h0000);
    tbl[5]  = V(0,0,16'h0000, 0,0,0,0, 1,1, 0,0, 16'hBEEF,16'h1234,8'h00,0,16'h0000);
    tbl[6]  = V(0,0,16'h0000, 0,2,0,0, 0,0, 1,2, 16'hFFFF,16'hFFFF,8'h00,0,16'hFFFF);
    tbl[7]  = V(0,0,16'h0000, 0,2,0,0, 0,0, 0,0, 16'hFFFF,16'hFFFF,8'h04,1,16'hFFFF);
    tbl[8]  = V(1,2,16'h00AA, 0,2,0,0, 0,0, 0,0, 16'hFFFF,16'hFFFF,8'h04,0,16'hFFFF);
    tbl[9]  = V(1,6,16'hC0DE, 0,2,0,0, 0,0, 1,6, 16'hFFFF,16'hFFFF,8'h00,0,16'hFFFF);
    tbl[10] = V(0,0,16'h0000, 1,6,0,0, 0,0, 0,0, 16'hFFFF,16'hFFFF,8'h40,1,16'hFFFF);
    tbl[11] = V(0,0,16'h0000, 0,6,0,0, 1,0, 0,0, 16'hC0DE,16'hFFFF,8'h40,1,16'hFFFF);
    tbl[12] = V(1,1,16'h7777, 0,1,0,0, 1,0, 1,3, 16'hC0DE,16'hFFFF,8'h40,0,16'hFFFF);
    tbl[13] = V(0,0,16'h0000, 1,3,1,3, 1,0, 0,0, 16'hC0DE,16'hFFFF,8'h48,1,16'hFFFF);
    tbl[14] = V(0,0,16'h0000, 0,3,0,0, 1,1, 0,0, 16'hBEEF,16'hBEEF,8'h48,1,16'hBEEF);
    tbl[15] = V(0,0,16'h0000, 0,6,0,0, 0,0, 1,6, 16'hFFFF,16'hFFFF,8'h48,1,16'hFFFF);
    tbl[16] = V(0,0,16'h0000, 0,0,0,0, 0,0, 0,0, 16'hFFFF,16'hFFFF,8'h48,0,16'hFFFF);

    // Reset with bus 0 enabled and bus 1 released
    set_idle();
    Rst = 1'b1; Oe0 = 1'b1;
    advance();
    set_idle();
    Oe0 = 1'b1;
    #2;
    chk("rst_qz0", qa0, 16'h0000);
    chk("rst_qz1", qa1, RELEASED);
    chk("rst_busy", ma, 8'h00);
    chk("rst_hit", {ha0, ha1}, 2'b00);
    check_model();
    advance();

    foreach (tbl[i]) begin
      set_idle();
      Wr = tbl[i].wr; WAddr = tbl[i].waddr; WData = tbl[i].wdata;
      Rd0 = tbl[i].rd0; RAddr0 = tbl[i].ra0; Rd1 = tbl[i].rd1; RAddr1 = tbl[i].ra1;
      Oe0 = tbl[i].oe0; Oe1 = tbl[i].oe1; Rsv = tbl[i].rsv; RsvAddr = tbl[i].rsva;
      #2;
      chk($sformatf("tbl%0d_qz0", i), qa0, tbl[i].q0);
      chk($sformatf("tbl%0d_qz1", i), qa1, tbl[i].q1);
      chk($sformatf("tbl%0d_busy", i), ma, tbl[i].busy);
      chk($sformatf("tbl%0d_hit0", i), ha0, tbl[i].hit0);
      chk($sformatf("tbl%0d_zqz1", i), qb1, tbl[i].zq1);
      check_model();
      advance();
    end

    // Hardwired zero entry: write and reserve of entry 0 ignored by dut_b
    set_idle();
    Wr = 1'b1; WAddr = 3'd0; WData = 16'hFFFF; Rsv = 1'b1; RsvAddr = 3'd0;
    #2; check_model(); advance();
    set_idle();
    Rd0 = 1'b1; RAddr0 = 3'd0;
    #2; check_model(); advance();
    set_idle();
    Oe0 = 1'b1;
    #2;
    chk("zero_qz0", qb0, 16'h0000);
    chk("zero_busy0", mb[0], 1'b0);
    chk("nozero_busy0", ma[0], 1'b1);
    check_model();
    advance();

    // Reset in the same cycle as a reserve and a read capture
    set_idle();
    Rst = 1'b1; Rsv = 1'b1; RsvAddr = 3'd1; Rd0 = 1'b1; RAddr0 = 3'd3;
    #2; check_model(); advance();
    set_idle();
    Oe0 = 1'b1; Oe1 = 1'b1;
    #2;
    chk("midrst_qz0", qa0, 16'h0000);
    chk("midrst_busy", ma, 8'h00);
    chk("midrst_zqz0", qb0, 16'h0000);
    check_model();
    advance();
    for (int d = 0; d < D; d++) begin
      set_idle();
      Rd1 = 1'b1; RAddr1 = d[A-1:0];
      #2; check_model(); advance();
      set_idle();
      Oe1 = 1'b1;
      #2;
      chk($sformatf("midrst_entry%0d", d), qa1, 16'h0000);
      check_model();
      advance();
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      set_idle();
      Rst     = ($urandom_range(0, 49) == 0);
      Wr      = $urandom_range(0, 1);
      WAddr   = $urandom_range(0, D-1);
      WData   = $urandom;
      Rd0     = $urandom_range(0, 1);
      RAddr0  = $urandom_range(0, D-1);
      Rd1     = $urandom_range(0, 1);
      RAddr1  = $urandom_range(0, D-1);
      Oe0     = $urandom_range(0, 1);
      Oe1     = $urandom_range(0, 1);
      Rsv     = $urandom_range(0, 1);
      RsvAddr = $urandom_range(0, D-1);
      #2;
      check_model();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
